vm_change_dispenser: RTL and testbench
======================================

// Module: vm_change_dispenser
// PURPOSE
//  Downstream actuator stage of vending_machine_multi_v2. Consumes its dispense_A/dispense_B/change outputs.
//  Queues each sale, then runs the product vend motor and ejects the change one 5-unit coin at a time.
//  Coin ejection uses a hopper eject/sense handshake with a timeout.
//  Back-pressures the vending FSM via busy and latches a sticky fault on a hopper jam.
// PARAMETERS
//  DEPTH          4    request FIFO entries (power of 2, >=2)
//  VEND_CYCLES    8    cycles vend_A/vend_B held high per sale (>=1)
//  SENSE_TIMEOUT  16   cycles hop_eject may stay high awaiting hop_sense (>=2)
//  MAX_RETRIES    2    re-eject attempts per coin after timeout (only with VM_JAM_RETRY_EN)
// PORTS
//  clk         in   1  system clock, rising edge
//  reset       in   1  synchronous, active-high; clears all state incl. fault
//  dispense_A  in   1  1-cycle pulse: product A sold
//  dispense_B  in   1  1-cycle pulse: product B sold
//  change      in   2  change owed with this sale: 00=0, 01=5, 10=10, 11=15 units
//  hop_sense   in   1  hopper coin-exit sensor, 1-cycle pulse per coin
//  vend_A      out  1  product A motor enable
//  vend_B      out  1  product B motor enable
//  hop_eject   out  1  hopper eject request, level
//  busy        out  1  FIFO full OR fault; upstream must not issue a sale
//  idle        out  1  FIFO empty AND FSM in IDLE
//  fault       out  1  sticky hopper jam
//  req_err     out  1  1-cycle pulse: request dropped (overflow, A&B together, or during fault)
//  coins_paid  out  8  running count of coins sensed, wraps 255->0
// BEHAVIOUR
//  Reset values: all outputs 0 except idle=1; FIFO empty; FSM IDLE; counters 0.
//  Capture
//  - An edge with exactly one of dispense_A/B high pushes {prod, coins=change} into the FIFO.
//  - change is sampled in the same cycle as the dispense pulse.
//  - Both dispense_A and dispense_B high: no push, req_err=1.
//  - Push when busy=1: dropped, req_err=1. No push-through, even when a pop happens in the same cycle.
//  - change with no dispense pulse: ignored.
//  FSM: IDLE -> VEND -> [EJECT <-> GAP] -> IDLE; any state -> FAULT.
//  - IDLE: if FIFO non-empty, pop it; next state VEND.
//    * vend_A or vend_B rises on the edge after the push edge (latency 1).
//  - VEND: motor high for exactly VEND_CYCLES cycles.
//    * Then EJECT if coins>0, else IDLE.
//  - EJECT: hop_eject=1 and the timeout counter runs.
//    * hop_sense high: coins_paid+1, remaining-1, hop_eject drops next edge.
//      Go to GAP if remaining>0, else IDLE.
//    * SENSE_TIMEOUT cycles pass with no sense: timeout (see CONFIGURATION).
//    * hop_sense on the timeout cycle itself counts as success.
//  - GAP: one cycle with hop_eject=0, then EJECT. Retry counter is cleared per new coin.
//  - FAULT: vend_*=0, hop_eject=0, fault=1, busy=1. FIFO contents kept but not served. Exit only by reset.
//  hop_sense outside EJECT: ignored, no count.
//  Reset mid-operation: motors and eject drop on the reset edge; queued sales are lost.
// CONFIGURATION
//  VM_JAM_RETRY_EN defined:
//  - A timeout goes to GAP and re-ejects the same coin, up to MAX_RETRIES times.
//  - The next timeout after that goes to FAULT.
//  VM_JAM_RETRY_EN undefined:
//  - The first timeout goes to FAULT. MAX_RETRIES is unused.
// STRUCTURE
//  vm_pkg
//  - Change encoding constants (CHG_0/5/10/15).
//  - Product id typedef.
//  - FSM state enum (IDLE, VEND, EJECT, GAP, FAULT).
//  - Request record {prod, coins[1:0]}.
//  Sub-module vm_req_fifo
//  - Synchronous DEPTH-entry FIFO with push/pop/full/empty.
//  - Pointer wrap is on DEPTH.
//  Top level: FSM plus vend, timeout, retry and coins_paid counters.
// TESTING
//  1. dispense_A + change=00 -> vend_A high cycles 2..9 after the pulse, no hop_eject, then idle=1.
//  2. dispense_B + change=11, hop_sense 3 cycles after each eject rise -> 3 eject pulses, coins_paid=3.
//  3. 5 back-to-back sales (DEPTH=4), FSM busy -> busy=1 after 4th, 5th gives req_err, only 4 served.
//  4. dispense_A and dispense_B in same cycle -> req_err pulse, FIFO unchanged, no motor.
//  5. change=01, hop_sense never -> retry build: 3 eject windows of 16 then fault=1.
//     No-retry build: fault=1 after 16 cycles. busy=1 in both.
//  6. reset asserted mid-EJECT with 2 sales queued -> next cycle all outputs at reset values.
//     Further sales served normally.

Source files
------------

// File: rtl/vm_pkg.sv
// -----------------------------------------------------------------------------
// vm_pkg
// Shared types and constants for the vending-machine change dispenser.
//   - Change encoding constants (number of 5-unit coins owed)
//   - Product id type
//   - FSM state encoding (legacy-compatible localparam constants)
//   - Request record queued per sale, plus a helper that builds one
// -----------------------------------------------------------------------------
package vm_pkg;

  // Change encoding: the 2-bit code is directly the number of 5-unit coins.
  localparam logic [1:0] CHG_0  = 2'b00;
  localparam logic [1:0] CHG_5  = 2'b01;
  localparam logic [1:0] CHG_10 = 2'b10;
  localparam logic [1:0] CHG_15 = 2'b11;

  typedef enum logic {
    PROD_A = 1'b0,
    PROD_B = 1'b1
  } prod_e;

  // FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_VEND  = 3'd1;
  localparam state_t ST_EJECT = 3'd2;
  localparam state_t ST_GAP   = 3'd3;
  localparam state_t ST_FAULT = 3'd4;

  typedef struct packed {
    prod_e      prod;
    logic [1:0] coins;
  } req_t;

  // Build a request record from the product select and the change code.
  function automatic req_t req_make(input logic sel_b, input logic [1:0] chg);
    req_t r;
    r.prod  = sel_b ? PROD_B : PROD_A;
    r.coins = chg;
    return r;
  endfunction

endpackage

// File: rtl/vm_req_fifo.sv
// -----------------------------------------------------------------------------
// vm_req_fifo
// Synchronous DEPTH-entry request FIFO. Pointers wrap explicitly at DEPTH.
// The head entry is presented combinationally on pop_data.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   push, push_data     write request (ignored when full)
//   pop                 remove head entry (ignored when empty)
//   pop_data            current head entry
//   full, empty         occupancy flags
// -----------------------------------------------------------------------------
module vm_req_fifo
  import vm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  req_t push_data,
  input  logic pop,
  output req_t pop_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  req_t          mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == '0);
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign pop_data  = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy count
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= (wr_ptr_r == PTR_LAST) ? '0 : wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? '0 : rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/vm_change_dispenser.sv
// -----------------------------------------------------------------------------
// vm_change_dispenser
// Actuator stage behind the vending FSM: queues each sale, runs the product
// vend motor for VEND_CYCLES, then ejects the change one coin at a time using
// a hopper eject/sense handshake with a timeout. A hopper jam latches a sticky
// fault that only reset clears.
// Optional feature: define VM_JAM_RETRY_EN to re-eject a timed-out coin up to
// MAX_RETRIES times before faulting; otherwise the first timeout faults.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   dispense_A/B, change  sale pulse and change owed (coins of 5 units)
//   hop_sense             hopper coin-exit pulse
//   vend_A/B              product motor enables
//   hop_eject             hopper eject request (level)
//   busy                  FIFO full or fault: upstream must hold off
//   idle                  FIFO empty and FSM idle
//   fault                 sticky hopper jam
//   req_err               one-cycle pulse on a dropped request
//   coins_paid            running count of sensed coins (wraps)
// -----------------------------------------------------------------------------
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int VEND_CYCLES   = 8,
  parameter int SENSE_TIMEOUT = 16,
  parameter int MAX_RETRIES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dispense_A,
  input  logic       dispense_B,
  input  logic [1:0] change,
  input  logic       hop_sense,
  output logic       vend_A,
  output logic       vend_B,
  output logic       hop_eject,
  output logic       busy,
  output logic       idle,
  output logic       fault,
  output logic       req_err,
  output logic [7:0] coins_paid
);

  localparam int VW = $clog2(VEND_CYCLES + 1);
  localparam int TW = $clog2(SENSE_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRIES + 2);
  localparam logic [VW-1:0] VEND_LAST = VW'(VEND_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(SENSE_TIMEOUT - 1);
`ifdef VM_JAM_RETRY_EN
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);
`else
  localparam logic [RW-1:0] RETRY_LIMIT = '0;
`endif

  state_t        state_r;
  logic          vend_a_r;
  logic          vend_b_r;
  logic          hop_eject_r;
  logic          fault_r;
  logic          req_err_r;
  logic [7:0]    coins_paid_r;
  logic [1:0]    coins_r;
  logic [VW-1:0] vend_cnt_r;
  logic [TW-1:0] tmo_cnt_r;
  logic [RW-1:0] retry_cnt_r;

  logic one_hot_s;
  logic both_s;
  logic busy_s;
  logic push_s;
  logic pop_s;
  logic fifo_full_s;
  logic fifo_empty_s;
  req_t head_s;

  assign one_hot_s = dispense_A ^ dispense_B;
  assign both_s    = dispense_A & dispense_B;
  assign busy_s    = fifo_full_s | fault_r;
  // busy is evaluated on this cycle's registers, so a same-cycle pop never
  // makes room for a push into a full FIFO.
  assign push_s    = one_hot_s & ~busy_s;
  assign pop_s     = (state_r == ST_IDLE) & ~fifo_empty_s;

  vm_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (req_make(dispense_B, change)),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Sequencing FSM with registered motor, eject, fault and error outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      vend_a_r     <= 1'b0;
      vend_b_r     <= 1'b0;
      hop_eject_r  <= 1'b0;
      fault_r      <= 1'b0;
      req_err_r    <= 1'b0;
      coins_paid_r <= 8'd0;
      coins_r      <= 2'd0;
      vend_cnt_r   <= '0;
      tmo_cnt_r    <= '0;
      retry_cnt_r  <= '0;
    end else begin
      req_err_r <= both_s | (one_hot_s & busy_s);
      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            state_r    <= ST_VEND;
            vend_a_r   <= (head_s.prod == PROD_A);
            vend_b_r   <= (head_s.prod == PROD_B);
            coins_r    <= head_s.coins;
            vend_cnt_r <= '0;
          end
        end
        ST_VEND: begin
          if (vend_cnt_r == VEND_LAST) begin
            vend_a_r    <= 1'b0;
            vend_b_r    <= 1'b0;
            tmo_cnt_r   <= '0;
            retry_cnt_r <= '0;
            if (coins_r != CHG_0) begin
              state_r     <= ST_EJECT;
              hop_eject_r <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            vend_cnt_r <= vend_cnt_r + VW'(1);
          end
        end
        ST_EJECT: begin
          // A sense on the final timeout cycle still counts as success.
          if (hop_sense) begin
            coins_paid_r <= coins_paid_r + 8'd1;
            coins_r      <= coins_r - 2'd1;
            hop_eject_r  <= 1'b0;
            retry_cnt_r  <= '0;
            state_r      <= (coins_r == 2'd1) ? ST_IDLE : ST_GAP;
          end else if (tmo_cnt_r == TMO_LAST) begin
            hop_eject_r <= 1'b0;
            if (retry_cnt_r < RETRY_LIMIT) begin
              retry_cnt_r <= retry_cnt_r + RW'(1);
              state_r     <= ST_GAP;
            end else begin
              state_r <= ST_FAULT;
              fault_r <= 1'b1;
            end
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end
        ST_GAP: begin
          state_r     <= ST_EJECT;
          hop_eject_r <= 1'b1;
          tmo_cnt_r   <= '0;
        end
        ST_FAULT: begin
          vend_a_r    <= 1'b0;
          vend_b_r    <= 1'b0;
          hop_eject_r <= 1'b0;
          fault_r     <= 1'b1;
        end
        default: begin
          // Unreachable encoding: fail safe into the jam state.
          state_r     <= ST_FAULT;
          vend_a_r    <= 1'b0;
          vend_b_r    <= 1'b0;
          hop_eject_r <= 1'b0;
          fault_r     <= 1'b1;
        end
      endcase
    end
  end

  assign vend_A     = vend_a_r;
  assign vend_B     = vend_b_r;
  assign hop_eject  = hop_eject_r;
  assign fault      = fault_r;
  assign req_err    = req_err_r;
  assign coins_paid = coins_paid_r;
  assign busy       = busy_s;
  assign idle       = fifo_empty_s & (state_r == ST_IDLE);

endmodule

// File: tb/tb_vm_change_dispenser.sv
module tb_vm_change_dispenser;

  localparam int VEND_N = 8;
  localparam int TMO_N  = 16;
`ifdef VM_JAM_RETRY_EN
  localparam int EXP_WINDOWS = 3;
`else
  localparam int EXP_WINDOWS = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dispense_A = 1'b0;
  logic       dispense_B = 1'b0;
  logic [1:0] change = 2'b00;
  logic       hop_sense = 1'b0;
  logic       vend_A, vend_B, hop_eject, busy, idle, fault, req_err;
  logic [7:0] coins_paid;

  typedef struct {
    bit       is_b;
    int       coins;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   resp_en = 1'b0;

  vm_change_dispenser dut (
    .clk        (clk),
    .reset      (reset),
    .dispense_A (dispense_A),
    .dispense_B (dispense_B),
    .change     (change),
    .hop_sense  (hop_sense),
    .vend_A     (vend_A),
    .vend_B     (vend_B),
    .hop_eject  (hop_eject),
    .busy       (busy),
    .idle       (idle),
    .fault      (fault),
    .req_err    (req_err),
    .coins_paid (coins_paid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle sale; optionally record it as expected to be served.
  task automatic sale(input bit a, input bit b, input logic [1:0] chg, input bit expect_served);
    exp_t e;
    dispense_A = a;
    dispense_B = b;
    change     = chg;
    if (expect_served) begin
      e.is_b  = b;
      e.coins = int'(chg);
      exp_q.push_back(e);
    end
    tick(1);
    dispense_A = 1'b0;
    dispense_B = 1'b0;
    change     = 2'b00;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (!idle && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!idle) check_eq({tag, "_idle_timeout"}, 0, 1);
  endtask

  task automatic wait_eject(input string tag, input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (!hop_eject && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!hop_eject) check_eq({tag, "_eject_timeout"}, 0, 1);
  endtask

  // Hopper model: answer each eject with a sense pulse 3 cycles after it rises.
  initial begin
    forever begin
      @(posedge hop_eject);
      if (resp_en) begin
        repeat (2) @(posedge clk);
        #1 hop_sense = 1'b1;
        @(posedge clk);
        #1 hop_sense = 1'b0;
      end
    end
  end

  // Scoreboard monitor: pops one expected sale per vend rise and checks
  // product, motor length, eject count and coins_paid increment.
  initial begin
    bit   vprev, eprev, iprev, active;
    int   vlen, ejs;
    logic [7:0] paid0, dpaid;
    exp_t cur;
    vprev = 0; eprev = 0; iprev = 1; active = 0; vlen = 0; ejs = 0; paid0 = 8'd0;
    cur.is_b = 0; cur.coins = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        vprev = 0; eprev = 0; iprev = 1; active = 0;
      end else begin
        if ((vend_A | vend_B) && !vprev) begin
          if (active) begin
            dpaid = coins_paid - paid0;
            check_eq("sb_ejects", ejs, cur.coins);
            check_eq("sb_paid", int'(dpaid), cur.coins);
          end
          if (exp_q.size() == 0) begin
            check_eq("sb_unexpected_vend", 1, 0);
            cur.is_b = vend_B; cur.coins = 0;
          end else begin
            cur = exp_q.pop_front();
            check_eq("sb_prod", int'({vend_B, vend_A}), cur.is_b ? 2 : 1);
          end
          active = 1; vlen = 1; ejs = 0; paid0 = coins_paid;
        end else if (vend_A | vend_B) begin
          vlen++;
        end
        if (!(vend_A | vend_B) && vprev) check_eq("sb_vend_len", vlen, VEND_N);
        if (hop_eject && !eprev) ejs++;
        if (idle && !iprev && active) begin
          dpaid = coins_paid - paid0;
          check_eq("sb_ejects", ejs, cur.coins);
          check_eq("sb_paid", int'(dpaid), cur.coins);
          active = 0;
        end
        vprev = vend_A | vend_B;
        eprev = hop_eject;
        iprev = idle;
      end
    end
  end

  initial begin
    int hi, rises;
    bit eprev;

    // Reset state
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_vend", int'({vend_A, vend_B}), 0);
    check_eq("rst_eject", int'(hop_eject), 0);
    check_eq("rst_busy_fault", int'({busy, fault, req_err}), 0);
    check_eq("rst_idle", int'(idle), 1);
    check_eq("rst_paid", int'(coins_paid), 0);
    mon_en  = 1'b1;
    resp_en = 1'b1;
    tick(1);

    // 1: product A, no change; vend_A high in cycles 2..9 after the pulse
    sale(1'b1, 1'b0, 2'b00, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check_eq($sformatf("t1_vendA_c%0d", k), int'(vend_A), (k >= 2 && k <= 9) ? 1 : 0);
      check_eq("t1_no_eject", int'(hop_eject), 0);
    end
    check_eq("t1_idle", int'(idle), 1);
    check_eq("t1_req_err", int'(req_err), 0);

    // 2: product B, 15 units owed -> three coins
    tick(1);
    sale(1'b0, 1'b1, 2'b11, 1'b1);
    wait_idle("t2", 200);
    check_eq("t2_paid", int'(coins_paid), 3);

    // 3: one sale vending, then 5 back-to-back; 5th dropped
    tick(1);
    sale(1'b1, 1'b0, 2'b00, 1'b1);
    tick(1);
    sale(1'b1, 1'b0, 2'b01, 1'b1);
    @(negedge clk);
    check_eq("t3_req_err_ok", int'(req_err), 0);
    #1;
    sale(1'b0, 1'b1, 2'b00, 1'b1);
    sale(1'b1, 1'b0, 2'b10, 1'b1);
    sale(1'b0, 1'b1, 2'b00, 1'b1);
    dispense_A = 1'b1;
    change     = 2'b11;
    @(negedge clk);
    check_eq("t3_busy_full", int'(busy), 1);
    @(posedge clk);
    #1;
    dispense_A = 1'b0;
    change     = 2'b00;
    @(negedge clk);
    check_eq("t3_req_err_drop", int'(req_err), 1);
    wait_idle("t3", 400);
    check_eq("t3_paid", int'(coins_paid), 6);
    check_eq("t3_busy_after", int'(busy), 0);

    // 4: both dispense lines together -> error pulse, nothing queued
    tick(1);
    sale(1'b1, 1'b1, 2'b10, 1'b0);
    @(negedge clk);
    check_eq("t4_req_err", int'(req_err), 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("t4_no_motor", int'({vend_A, vend_B}), 0);
    end
    check_eq("t4_idle", int'(idle), 1);

    // 5: hopper never senses -> timeout windows, then sticky fault
    mon_en  = 1'b0;
    resp_en = 1'b0;
    #1;
    sale(1'b1, 1'b0, 2'b01, 1'b0);
    hi = 0; rises = 0; eprev = 0;
    for (int k = 0; k < 300 && !fault; k++) begin
      @(negedge clk);
      if (hop_eject) hi++;
      if (hop_eject && !eprev) rises++;
      eprev = hop_eject;
    end
    check_eq("t5_fault", int'(fault), 1);
    check_eq("t5_windows", rises, EXP_WINDOWS);
    check_eq("t5_eject_cycles", hi, EXP_WINDOWS * TMO_N);
    check_eq("t5_busy", int'(busy), 1);
    check_eq("t5_eject_off", int'(hop_eject), 0);
    #1;
    sale(1'b0, 1'b1, 2'b00, 1'b0);
    @(negedge clk);
    check_eq("t5_req_err_fault", int'(req_err), 1);
    tick(3);
    check_eq("t5_fault_sticky", int'({fault, vend_A, vend_B}), 4);

    // 6: reset mid-EJECT with two sales queued
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    sale(1'b1, 1'b0, 2'b11, 1'b0);
    sale(1'b0, 1'b1, 2'b01, 1'b0);
    sale(1'b1, 1'b0, 2'b00, 1'b0);
    wait_eject("t6", 50);
    #1;
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check_eq("t6_rst_outs", int'({vend_A, vend_B, hop_eject, busy, fault, req_err}), 0);
    check_eq("t6_rst_idle", int'(idle), 1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_eq("t6_lost_sales", int'({vend_A, vend_B}), 0);
    end
    mon_en  = 1'b1;
    resp_en = 1'b1;
    #1;
    sale(1'b0, 1'b1, 2'b10, 1'b1);
    wait_idle("t6", 200);
    check_eq("t6_paid", int'(coins_paid), 2);
    tick(2);
    check_eq("sb_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=%0d exp=%0d", 0, 1);
    $fatal(1, "watchdog expired");
  end

endmodule
